// File: rtl/eq_mix_scheduler.sv
// Gain-and-mix engine: one shared signed multiplier walks low/high/band through a
// 34-bit accumulator, then saturates to 16 bits and ramps the gains toward their targets.
module eq_mix_scheduler #(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 16,
    parameter int FRAC      = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data_low,
    input  logic [DATA_W-1:0] data_high,
    input  logic [DATA_W-1:0] data_band,
    input  logic [GAIN_W-1:0] gain_low_tgt,
    input  logic [GAIN_W-1:0] gain_high_tgt,
    input  logic [GAIN_W-1:0] gain_band_tgt,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              overflow,
    output logic              sample_drop,
    output logic              gains_settled
);

    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int ACC_W  = PROD_W + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX_C =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN_C =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [GAIN_W+1:0] STEP_C = (GAIN_W+2)'(RAMP_STEP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC_L = 3'd1,
        MAC_H = 3'd2,
        MAC_B = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Move cur one step toward tgt; two guard bits keep the difference exact.
    function automatic logic signed [GAIN_W-1:0] ramp_gain(
        input logic signed [GAIN_W-1:0] cur,
        input logic signed [GAIN_W-1:0] tgt
    );
        logic signed [GAIN_W+1:0] cur_x;
        logic signed [GAIN_W+1:0] diff;
        cur_x = {{2{cur[GAIN_W-1]}}, cur};
        diff  = {{2{tgt[GAIN_W-1]}}, tgt} - cur_x;
        if (diff > STEP_C) begin
            ramp_gain = GAIN_W'(cur_x + STEP_C);
        end else if (diff < -STEP_C) begin
            ramp_gain = GAIN_W'(cur_x - STEP_C);
        end else begin
            ramp_gain = tgt;
        end
    endfunction

    state_t state_r;
    state_t state_next_s;

    logic signed [DATA_W-1:0] x_low_r;
    logic signed [DATA_W-1:0] x_high_r;
    logic signed [DATA_W-1:0] x_band_r;
    logic signed [GAIN_W-1:0] tgt_low_r;
    logic signed [GAIN_W-1:0] tgt_high_r;
    logic signed [GAIN_W-1:0] tgt_band_r;
    logic signed [GAIN_W-1:0] cur_low_r;
    logic signed [GAIN_W-1:0] cur_high_r;
    logic signed [GAIN_W-1:0] cur_band_r;
    logic signed [ACC_W-1:0]  acc_r;

    logic signed [GAIN_W-1:0] mul_gain_s;
    logic signed [DATA_W-1:0] mul_data_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic [DATA_W-1:0]        sat_dout_s;
    logic                     sat_ovf_s;
    logic signed [GAIN_W-1:0] ramp_low_s;
    logic signed [GAIN_W-1:0] ramp_high_s;
    logic signed [GAIN_W-1:0] ramp_band_s;
    logic                     accept_s;

    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;
    logic              overflow_r;
    logic              sample_drop_r;
    logic              gains_settled_r;
    logic              busy_r;

    assign accept_s = (state_r == IDLE) && sample_valid;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing: fixed five-cycle walk per accepted sample.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sample_valid) begin
                    state_next_s = MAC_L;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MAC_L:   state_next_s = MAC_H;
            MAC_H:   state_next_s = MAC_B;
            MAC_B:   state_next_s = OUT;
            OUT:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand mux for the single shared multiplier.
    always_comb begin
        mul_gain_s = {GAIN_W{1'b0}};
        mul_data_s = {DATA_W{1'b0}};
        case (state_r)
            MAC_L: begin
                mul_gain_s = cur_low_r;
                mul_data_s = x_low_r;
            end
            MAC_H: begin
                mul_gain_s = cur_high_r;
                mul_data_s = x_high_r;
            end
            MAC_B: begin
                mul_gain_s = cur_band_r;
                mul_data_s = x_band_r;
            end
            default: begin
                mul_gain_s = {GAIN_W{1'b0}};
                mul_data_s = {DATA_W{1'b0}};
            end
        endcase
    end

    assign prod_s     = mul_gain_s * mul_data_s;
    assign prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};

    // Floor shift back to sample scale, then clamp to the 16-bit range.
    always_comb begin
        shifted_s  = acc_r >>> FRAC;
        sat_dout_s = shifted_s[DATA_W-1:0];
        sat_ovf_s  = 1'b0;
        if (shifted_s > SAT_MAX_C) begin
            sat_dout_s = SAT_MAX_C[DATA_W-1:0];
            sat_ovf_s  = 1'b1;
        end else if (shifted_s < SAT_MIN_C) begin
            sat_dout_s = SAT_MIN_C[DATA_W-1:0];
            sat_ovf_s  = 1'b1;
        end else begin
            sat_dout_s = shifted_s[DATA_W-1:0];
            sat_ovf_s  = 1'b0;
        end
    end

    assign ramp_low_s  = ramp_gain(cur_low_r, tgt_low_r);
    assign ramp_high_s = ramp_gain(cur_high_r, tgt_high_r);
    assign ramp_band_s = ramp_gain(cur_band_r, tgt_band_r);

    // Snapshot of samples and targets, taken only when a strobe is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_low_r    <= {DATA_W{1'b0}};
            x_high_r   <= {DATA_W{1'b0}};
            x_band_r   <= {DATA_W{1'b0}};
            tgt_low_r  <= {GAIN_W{1'b0}};
            tgt_high_r <= {GAIN_W{1'b0}};
            tgt_band_r <= {GAIN_W{1'b0}};
        end else if (accept_s) begin
            x_low_r    <= data_low;
            x_high_r   <= data_high;
            x_band_r   <= data_band;
            tgt_low_r  <= gain_low_tgt;
            tgt_high_r <= gain_high_tgt;
            tgt_band_r <= gain_band_tgt;
        end
    end

    // Accumulator: load on the first band, add on the other two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                MAC_L:        acc_r <= prod_ext_s;
                MAC_H, MAC_B: acc_r <= acc_r + prod_ext_s;
                default:      acc_r <= acc_r;
            endcase
        end
    end

    // Output stage and gain ramp; gains change only after this sample's MAC used them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r          <= {DATA_W{1'b0}};
            overflow_r      <= 1'b0;
            dout_valid_r    <= 1'b0;
            cur_low_r       <= {GAIN_W{1'b0}};
            cur_high_r      <= {GAIN_W{1'b0}};
            cur_band_r      <= {GAIN_W{1'b0}};
            gains_settled_r <= 1'b1;
        end else begin
            dout_valid_r <= 1'b0;
            if (state_r == OUT) begin
                dout_r          <= sat_dout_s;
                overflow_r      <= sat_ovf_s;
                dout_valid_r    <= 1'b1;
                cur_low_r       <= ramp_low_s;
                cur_high_r      <= ramp_high_s;
                cur_band_r      <= ramp_band_s;
                gains_settled_r <= (ramp_low_s == tgt_low_r) &&
                                   (ramp_high_s == tgt_high_r) &&
                                   (ramp_band_s == tgt_band_r);
            end
        end
    end

    // Status flags: drop pulse and busy, both registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_drop_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            sample_drop_r <= sample_valid && (state_r != IDLE);
            busy_r        <= (state_next_s != IDLE);
        end
    end

    assign busy          = busy_r;
    assign dout          = dout_r;
    assign dout_valid    = dout_valid_r;
    assign overflow      = overflow_r;
    assign sample_drop   = sample_drop_r;
    assign gains_settled = gains_settled_r;

endmodule
